// File: rtl/wb_target_mem.sv
// Wishbone classic target backed by a byte-lane writable register array.
// Programmable wait states before a one-cycle ack/err; an address outside the window gets err.
module wb_target_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_LOG2  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h3000_0000,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   dat_w,
  output logic                    ack,
  output logic                    err,
  output logic [DATA_WIDTH-1:0]   dat_r
);

  // state | meaning
  // IDLE  | waiting for cyc&stb; request fields captured on acceptance
  // WAIT  | counting down wait states; dropping cyc aborts the transfer
  // RESP  | one-cycle ack or err, always followed by IDLE
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       capture, enter_resp;

  logic                  lat_we;
  logic [NB-1:0]         lat_sel;
  logic [ADDR_WIDTH-3:0] lat_wadr;
  logic [DATA_WIDTH-1:0] lat_dat;

  logic                  cur_we;
  logic [NB-1:0]         cur_sel;
  logic [ADDR_WIDTH-3:0] cur_wadr;
  logic [DATA_WIDTH-1:0] cur_dat;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic unused_adr_lsb;
  assign unused_adr_lsb = ^adr[1:0];

  // With zero wait states the response is entered on the accepting edge, so the live bus is used.
  always_comb begin
    if (state == IDLE) begin
      cur_we   = we;
      cur_sel  = sel;
      cur_wadr = adr[ADDR_WIDTH-1:2];
      cur_dat  = dat_w;
    end else begin
      cur_we   = lat_we;
      cur_sel  = lat_sel;
      cur_wadr = lat_wadr;
      cur_dat  = lat_dat;
    end
  end

  assign in_range = (cur_wadr[ADDR_WIDTH-3:DEPTH_LOG2] == BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2+2]);
  assign idx      = cur_wadr[DEPTH_LOG2-1:0];
  assign wr_en    = reset_n && enter_resp && in_range && cur_we;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (cyc && stb) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      err   <= 1'b0;
      dat_r <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= enter_resp && in_range;
      err   <= enter_resp && !in_range;
      dat_r <= (enter_resp && in_range && !cur_we) ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      lat_we   <= we;
      lat_sel  <= sel;
      lat_wadr <= adr[ADDR_WIDTH-1:2];
      lat_dat  <= dat_w;
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_sel[i]) mem[idx][8*i +: 8] <= cur_dat[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_target_mem.sv
// Scoreboard bench for wb_target_mem: three instances with 1, 3 and 0 wait states.
// Drivers push expected responses; a negedge monitor pops and compares them.
module tb_wb_target_mem;

  typedef struct {
    logic        is_err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cyc_v   [3];
  logic        stb_v   [3];
  logic        we_v    [3];
  logic [3:0]  sel_v   [3];
  logic [31:0] adr_v   [3];
  logic [31:0] dat_w_v [3];
  logic        ack_v   [3];
  logic        err_v   [3];
  logic [31:0] dat_r_v [3];

  exp_t q0[$], q1[$], q2[$];
  bit   prev_resp [3];
  int   cycle = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  wb_target_mem #(.WAIT_STATES(1)) u_ws1 (
    .clock(clock), .reset_n(reset_n), .cyc(cyc_v[0]), .stb(stb_v[0]), .we(we_v[0]),
    .sel(sel_v[0]), .adr(adr_v[0]), .dat_w(dat_w_v[0]),
    .ack(ack_v[0]), .err(err_v[0]), .dat_r(dat_r_v[0]));

  wb_target_mem #(.WAIT_STATES(3)) u_ws3 (
    .clock(clock), .reset_n(reset_n), .cyc(cyc_v[1]), .stb(stb_v[1]), .we(we_v[1]),
    .sel(sel_v[1]), .adr(adr_v[1]), .dat_w(dat_w_v[1]),
    .ack(ack_v[1]), .err(err_v[1]), .dat_r(dat_r_v[1]));

  wb_target_mem #(.WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset_n(reset_n), .cyc(cyc_v[2]), .stb(stb_v[2]), .we(we_v[2]),
    .sel(sel_v[2]), .adr(adr_v[2]), .dat_w(dat_w_v[2]),
    .ack(ack_v[2]), .err(err_v[2]), .dat_r(dat_r_v[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
  endfunction

  task automatic q_push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   sz;
    check($sformatf("ack_err_exclusive[%0d]", d), {31'd0, ack_v[d] & err_v[d]}, 32'd0);
    if (!ack_v[d]) check($sformatf("dat_r_zero_without_ack[%0d]", d), dat_r_v[d], 32'd0);
    if (ack_v[d] || err_v[d]) begin
      sz = q_size(d);
      check($sformatf("resp_expected[%0d]", d), {31'd0, sz != 0}, 32'd1);
      check($sformatf("idle_gap[%0d]", d), {31'd0, prev_resp[d]}, 32'd0);
      if (sz != 0) begin
        case (d)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        check($sformatf("err_flag[%0d]", d), {31'd0, err_v[d]}, {31'd0, e.is_err});
        check($sformatf("dat_r[%0d]", d), dat_r_v[d], e.data);
        check($sformatf("latency[%0d]", d), cycle, e.due);
      end
    end
    prev_resp[d] = ack_v[d] | err_v[d];
  endtask

  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) mon(d);
  end

  task automatic xfer(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_data,
                      input bit scramble);
    exp_t e;
    bit   done;
    @(negedge clock);
    cyc_v[d] = 1'b1; stb_v[d] = 1'b1; we_v[d] = w;
    sel_v[d] = s; adr_v[d] = a; dat_w_v[d] = wd;
    @(posedge clock);
    #1;
    e.is_err = exp_err;
    e.data   = exp_data;
    e.due    = cycle + ws_of(d);
    q_push(d, e);
    if (scramble) begin
      we_v[d] = ~w; sel_v[d] = ~s; adr_v[d] = ~a; dat_w_v[d] = ~wd;
    end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (ack_v[d] || err_v[d]) done = 1'b1;
    end
    check($sformatf("ack_timeout[%0d]", d), {31'd0, done}, 32'd1);
    cyc_v[d] = 1'b0; stb_v[d] = 1'b0; we_v[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    xfer(d, 1'b1, s, a, wd, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp_data);
    xfer(d, 1'b0, 4'hF, a, 32'd0, 1'b0, exp_data, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [31:0] rdata;
    logic [31:0] raddr;
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cyc_v[d] = 1'b0; stb_v[d] = 1'b0; we_v[d] = 1'b0;
      sel_v[d] = 4'h0; adr_v[d] = 32'd0; dat_w_v[d] = 32'd0;
      prev_resp[d] = 1'b0;
    end
    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_ack[%0d]", d), {31'd0, ack_v[d]}, 32'd0);
      check($sformatf("reset_err[%0d]", d), {31'd0, err_v[d]}, 32'd0);
      check($sformatf("reset_dat_r[%0d]", d), dat_r_v[d], 32'd0);
    end
    reset_n = 1'b1;

    // one wait state: basic write/read, byte lanes, out-of-range, ignored address LSBs
    wr(0, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    rd(0, 32'h3000_0010, 32'hDEAD_BEEF);
    wr(0, 32'h3000_0020, 32'h1122_3344, 4'hF);
    wr(0, 32'h3000_0020, 32'hAABB_CCDD, 4'b0101);
    rd(0, 32'h3000_0020, 32'h11BB_33DD);
    wr(0, 32'h3000_0020, 32'hFFFF_FFFF, 4'h0);
    rd(0, 32'h3000_0020, 32'h11BB_33DD);
    xfer(0, 1'b0, 4'hF, 32'h3000_0400, 32'd0, 1'b1, 32'd0, 1'b0);
    xfer(0, 1'b1, 4'hF, 32'h3000_0410, 32'h0000_0000, 1'b1, 32'd0, 1'b0);
    rd(0, 32'h3000_0010, 32'hDEAD_BEEF);
    rd(0, 32'h3000_0013, 32'hDEAD_BEEF);

    // three wait states: abort, field capture, reset mid-transfer
    wr(1, 32'h3000_0000, 32'hCAFE_0001, 4'hF);
    @(negedge clock);
    cyc_v[1] = 1'b1; stb_v[1] = 1'b1; we_v[1] = 1'b1;
    sel_v[1] = 4'hF; adr_v[1] = 32'h3000_0000; dat_w_v[1] = 32'h5555_5555;
    @(posedge clock);
    @(negedge clock);
    cyc_v[1] = 1'b0; stb_v[1] = 1'b0; we_v[1] = 1'b0;
    repeat (6) @(negedge clock);
    rd(1, 32'h3000_0000, 32'hCAFE_0001);

    xfer(1, 1'b1, 4'hF, 32'h3000_0008, 32'h0102_0304, 1'b0, 32'd0, 1'b1);
    rd(1, 32'h3000_0008, 32'h0102_0304);

    wr(1, 32'h3000_0040, 32'h0BAD_F00D, 4'hF);
    @(negedge clock);
    cyc_v[1] = 1'b1; stb_v[1] = 1'b1; we_v[1] = 1'b1;
    sel_v[1] = 4'hF; adr_v[1] = 32'h3000_0040; dat_w_v[1] = 32'h1234_5678;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    cyc_v[1] = 1'b0; stb_v[1] = 1'b0; we_v[1] = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    rd(1, 32'h3000_0040, 32'h0BAD_F00D);
    rd(1, 32'h3000_0008, 32'h0102_0304);
    rd(0, 32'h3000_0020, 32'h11BB_33DD);

    // zero wait states: back-to-back write/read pairs with random data
    for (int k = 0; k < 5; k++) begin
      rdata = $urandom;
      raddr = 32'h3000_0000 + (32'($urandom_range(0, 255)) << 2);
      wr(2, raddr, rdata, 4'hF);
      rd(2, raddr, rdata);
    end

    repeat (8) @(negedge clock);
    for (int d = 0; d < 3; d++)
      check($sformatf("queue_drained[%0d]", d), 32'(q_size(d)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
